sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM master that reads the system ID peripheral and checks that the loaded hardware matches what software was built for. After reset, or on a `start` pulse, it reads word 0 (system ID) and then word 1 (build timestamp) from the sysid control slave. It compares both against parameters and reports done, pass and fault flags to the board status logic (LEDs/debug PIO). It sits in the Qsys system as a master connected only to the sysid slave.

## Interface
- `EXPECTED_ID`, 32'h0000_0000, value required at sysid word 0
- `EXPECTED_TS`, 32'd1358911882, value required at sysid word 1
- `TIMEOUT_CYCLES`, 255, maximum waitrequest-high cycles per read (1..65535)
- `AUTO_START`, 1, 1 = begin check automatically after reset release
- `clock` input 1 system clock, all logic rising-edge
- `reset_n` input 1 asynchronous, active-low reset
- `start` input 1 single-cycle request to (re)run the check
- `avm_address` output 1 word address to sysid slave
- `avm_read` output 1 Avalon read strobe
- `avm_readdata` input 32 read data, valid when `avm_read`=1 and `avm_waitrequest`=0
- `avm_waitrequest` input 1 slave stall
- `done` output 1 check finished; results valid
- `pass` output 1 ID and timestamp both matched, no timeout
- `id_mismatch` output 1 word 0 differed from `EXPECTED_ID`
- `ts_mismatch` output 1 word 1 differed from `EXPECTED_TS`
- `timeout` output 1 a read exceeded `TIMEOUT_CYCLES`
- `captured_ts` output 32 last timestamp read (0 if never read)

## Operation
- States: IDLE, RD_ID, RD_TS, DONE. All are registered; outputs decode from state and flag registers.
- IDLE: `avm_read`=0. Moves to RD_ID on the next edge if `AUTO_START`=1 (first cycle after reset) or `start`=1.
- RD_ID: `avm_read`=1, `avm_address`=0, both held stable while `avm_waitrequest`=1.
  - On an accepted cycle (`avm_waitrequest`=0): `id_mismatch` <= (`avm_readdata` != `EXPECTED_ID`), then go to RD_TS.
- RD_TS: same as RD_ID with `avm_address`=1.
  - On acceptance: `captured_ts` <= `avm_readdata`, `ts_mismatch` <= (data != `EXPECTED_TS`), then go to DONE.
- Timeout counter, 16 bits:
  - Cleared on entry to each read state and on acceptance.
  - Increments each cycle the read is stalled.
  - If a stalled cycle occurs with the count already equal to `TIMEOUT_CYCLES`: `timeout` <= 1 and go to DONE. The read is dropped, and the mismatch flag for the unread word stays 0.
- DONE: `done`=1, `avm_read`=0, `pass` = `!id_mismatch && !ts_mismatch && !timeout`.
  - `start` in DONE clears `done`, all fault flags and `captured_ts` on that edge, then goes to RD_ID.
- `start` in RD_ID or RD_TS is ignored; the operation is not restarted.
- No reads are issued outside RD_ID/RD_TS, and there is at most one outstanding access. Read latency is fixed at 0, so no readdatavalid is used.

## Timing
- Reset (async assert) values: state IDLE, `avm_read`=0, `avm_address`=0, `done`=0, `pass`=0, all fault flags 0, `captured_ts`=0, counter 0.
- With zero wait states and `AUTO_START`=1, counting from the first edge after reset release (edge 0):
  - After edge 0: RD_ID.
  - After edge 1: RD_TS.
  - After edge 2: DONE, `done`=1.
- Each wait-state cycle adds exactly one cycle.
- Timeout: the read is abandoned on the edge where stall count `TIMEOUT_CYCLES`+1 would occur. `done` rises the next cycle.
- `pass` is only meaningful while `done`=1 and is forced to 0 otherwise.
- `reset_n` low mid-read deasserts `avm_read` immediately (asynchronously). After release, behaviour is as from power-up.

## Test plan
- Slave returns 0 at word 0 and 1358911882 at word 1, no wait states. Required: reads to address 0 then 1, `done`=1 three edges after reset release, `pass`=1, `captured_ts`=1358911882.
- Same as above but the slave holds `avm_waitrequest`=1 for 3 cycles per read. Required: address and read held stable throughout, `done` six edges later than the zero-wait case, `pass`=1.
- Word 1 returns 32'h5100_0000. Required: `ts_mismatch`=1, `id_mismatch`=0, `pass`=0, `captured_ts`=32'h5100_0000.
- `avm_waitrequest` stuck high, `TIMEOUT_CYCLES`=4. Required: `timeout`=1, `pass`=0, `avm_read` low after the abort, no RD_TS access.
- `start` pulsed during RD_TS, then again in DONE with the slave fixed. Required: the first pulse is ignored; the second clears the flags and reruns the check, ending with `pass`=1.
- `reset_n` pulsed low during a stalled RD_ID. Required: outputs return to reset values immediately; the check reruns from IDLE after release.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid slave (system ID, then build timestamp)
// and reports whether the loaded hardware matches the expected build.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1358911882,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_ts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic [15:0] cnt_q, cnt_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        to_q, to_d;
  logic [31:0] cap_q, cap_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  // Next-state and next-output computation; outputs are decoded from the next
  // state so that every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    id_mm_d = id_mm_q;
    ts_mm_d = ts_mm_q;
    to_d    = to_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE: begin
        if ((AUTO_START && first_q) || start) begin
          state_d = RD_ID;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_mm_d = (avm_readdata != EXPECTED_ID);
          state_d = RD_TS;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_LIM) begin
          to_d    = 1'b1;
          state_d = DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          cap_d   = avm_readdata;
          ts_mm_d = (avm_readdata != EXPECTED_TS);
          state_d = DONE;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_LIM) begin
          to_d    = 1'b1;
          state_d = DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        // A rerun starts from a clean slate: stale results must not leak.
        if (start) begin
          id_mm_d = 1'b0;
          ts_mm_d = 1'b0;
          to_d    = 1'b0;
          cap_d   = 32'd0;
          cnt_d   = 16'd0;
          state_d = RD_ID;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
    done_d = (state_d == DONE);
    pass_d = done_d && !id_mm_d && !ts_mm_d && !to_d;
  end

  // State, flag and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      cnt_q   <= 16'd0;
      id_mm_q <= 1'b0;
      ts_mm_q <= 1'b0;
      to_q    <= 1'b0;
      cap_q   <= 32'd0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      id_mm_q <= id_mm_d;
      ts_mm_q <= ts_mm_d;
      to_q    <= to_d;
      cap_q   <= cap_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = to_q;
  assign captured_ts = cap_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: a sysid slave model with programmable
// wait states, plus a run-level reference model of timing and result flags.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1358911882;
  localparam int          T      = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic        done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] captured_ts;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [2];
  int          waits [2];
  bit          stuck;
  int          stalls;
  bit          prev_rd, prev_wr;
  logic        prev_addr;
  int          proto_err;
  bit          saw_addr1;
  bit          pass_glitch;
  bit          acc_q [$];

  sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(T),
    .AUTO_START(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .done(done),
    .pass(pass),
    .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch),
    .timeout(timeout),
    .captured_ts(captured_ts)
  );

  always #5 clock = ~clock;

  // Slave model: answers on the falling edge for the coming rising edge and
  // checks that a stalled request is held until accepted or abandoned.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      stalls = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (!done && pass) pass_glitch = 1'b1;
      if (prev_rd && prev_wr) begin
        stalls++;
        if (stalls <= T) begin
          if (!(avm_read && avm_address == prev_addr)) proto_err++;
        end else begin
          if (avm_read) proto_err++;
        end
      end else begin
        stalls = 0;
      end
      if (avm_read) begin
        if (avm_address) saw_addr1 = 1'b1;
        if (stuck || stalls < waits[avm_address]) begin
          avm_waitrequest = 1'b1;
          avm_readdata = $urandom;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = mem[avm_address];
          acc_q.push_back(avm_address);
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      prev_rd = avm_read;
      prev_wr = avm_waitrequest;
      prev_addr = avm_address;
    end
  end

  // Reference: edges from the launching edge until done is seen, and results.
  function automatic void predict(input int w0, input int w1,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  output int edges, output bit idm, output bit tsm,
                                  output bit to, output logic [31:0] cap, output int nacc);
    idm = 1'b0; tsm = 1'b0; to = 1'b0; cap = 32'd0;
    if (w0 > T) begin
      edges = (T + 1) + 1; to = 1'b1; nacc = 0;
    end else begin
      idm = (d0 != EXP_ID); nacc = 1;
      if (w1 > T) begin
        edges = (w0 + 1) + (T + 1) + 1; to = 1'b1;
      end else begin
        tsm = (d1 != EXP_TS); cap = d1; nacc = 2;
        edges = (w0 + 1) + (w1 + 1) + 1;
      end
    end
  endfunction

  task automatic config_slave(input int w0, input int w1, input logic [31:0] d0,
                              input logic [31:0] d1, input bit stk);
    waits[0] = w0; waits[1] = w1; mem[0] = d0; mem[1] = d1; stuck = stk;
    acc_q.delete(); proto_err = 0; saw_addr1 = 1'b0; pass_glitch = 1'b0;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic run_until_done(input int already, output int n);
    n = already;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    hold_reset();
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    start = 1'b0;
    tests_run++;
    if ({avm_read, avm_address, done, pass, id_mismatch, ts_mismatch, timeout} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {avm_read, avm_address, done, pass, id_mismatch, ts_mismatch, timeout});
    end
    tests_run++;
    if (captured_ts !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_captured_ts: got %h expected 00000000", captured_ts);
    end
  endtask

  task automatic test_zero_wait();
    int n;
    hold_reset();
    config_slave(0, 0, EXP_ID, EXP_TS, 1'b0);
    release_reset();
    run_until_done(0, n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL zw_latency: got %0d edges expected 3", n); end
    tests_run++;
    if (pass !== 1'b1) begin tests_failed++; $display("FAIL zw_pass: got %b expected 1", pass); end
    tests_run++;
    if (captured_ts !== EXP_TS) begin
      tests_failed++; $display("FAIL zw_captured: got %0d expected %0d", captured_ts, EXP_TS);
    end
    tests_run++;
    if (acc_q.size() != 2 || acc_q[0] !== 1'b0 || acc_q[1] !== 1'b1) begin
      tests_failed++; $display("FAIL zw_addr_order: got %p expected '{0,1}", acc_q);
    end
  endtask

  task automatic test_wait_states();
    int n;
    hold_reset();
    config_slave(3, 3, EXP_ID, EXP_TS, 1'b0);
    release_reset();
    run_until_done(0, n);
    tests_run++;
    if (n !== 9) begin tests_failed++; $display("FAIL ws_latency: got %0d edges expected 9", n); end
    tests_run++;
    if (pass !== 1'b1) begin tests_failed++; $display("FAIL ws_pass: got %b expected 1", pass); end
    tests_run++;
    if (proto_err !== 0) begin tests_failed++; $display("FAIL ws_hold_stable: got %0d errors expected 0", proto_err); end
  endtask

  task automatic test_ts_mismatch();
    int n;
    hold_reset();
    config_slave(0, 1, EXP_ID, 32'h5100_0000, 1'b0);
    release_reset();
    run_until_done(0, n);
    tests_run++;
    if ({ts_mismatch, id_mismatch, timeout, pass} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL tsmm_flags: got ts/id/to/pass=%b expected 1000",
               {ts_mismatch, id_mismatch, timeout, pass});
    end
    tests_run++;
    if (captured_ts !== 32'h5100_0000) begin
      tests_failed++; $display("FAIL tsmm_captured: got %h expected 51000000", captured_ts);
    end
  endtask

  task automatic test_timeout();
    int n;
    hold_reset();
    config_slave(0, 0, EXP_ID, EXP_TS, 1'b1);
    release_reset();
    run_until_done(0, n);
    tests_run++;
    if (n !== T + 2) begin tests_failed++; $display("FAIL to_latency: got %0d edges expected %0d", n, T + 2); end
    tests_run++;
    if ({timeout, pass, avm_read} !== 3'b100) begin
      tests_failed++; $display("FAIL to_flags: got to/pass/read=%b expected 100", {timeout, pass, avm_read});
    end
    tests_run++;
    if (saw_addr1 || acc_q.size() != 0 || proto_err != 0) begin
      tests_failed++;
      $display("FAIL to_no_ts_access: got addr1=%0d acc=%0d proto=%0d expected 0 0 0",
               saw_addr1, acc_q.size(), proto_err);
    end
  endtask

  task automatic test_start_ignored();
    int n, e, cnt;
    bit idm, tsm, to;
    logic [31:0] cap;
    hold_reset();
    config_slave(0, 3, EXP_ID, 32'hDEAD_BEEF, 1'b0);
    release_reset();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (avm_read && avm_address) break;
    end
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    run_until_done(cnt + 1, n);
    tests_run++;
    if (n !== 6 || ts_mismatch !== 1'b1 || acc_q.size() != 2) begin
      tests_failed++;
      $display("FAIL start_in_rdts: got edges=%0d tsmm=%b acc=%0d expected 6 1 2",
               n, ts_mismatch, acc_q.size());
    end
    config_slave(1, 2, EXP_ID, EXP_TS, 1'b0);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    tests_run++;
    if ({done, pass, ts_mismatch, id_mismatch, timeout} !== 5'd0 || captured_ts !== 32'd0) begin
      tests_failed++;
      $display("FAIL start_clears: got flags=%b cap=%h expected 00000 00000000",
               {done, pass, ts_mismatch, id_mismatch, timeout}, captured_ts);
    end
    run_until_done(1, n);
    predict(1, 2, EXP_ID, EXP_TS, e, idm, tsm, to, cap, cnt);
    tests_run++;
    if (n !== e || pass !== 1'b1 || captured_ts !== EXP_TS) begin
      tests_failed++;
      $display("FAIL rerun_pass: got edges=%0d pass=%b cap=%h expected %0d 1 %h", n, pass, captured_ts, e, EXP_TS);
    end
  endtask

  task automatic test_reset_midread();
    int n;
    hold_reset();
    config_slave(0, 0, EXP_ID, EXP_TS, 1'b1);
    release_reset();
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({avm_read, avm_address, done, pass, timeout} !== 5'd0) begin
      tests_failed++;
      $display("FAIL midread_reset: got read/addr/done/pass/to=%b expected 00000",
               {avm_read, avm_address, done, pass, timeout});
    end
    config_slave(2, 0, EXP_ID, EXP_TS, 1'b0);
    release_reset();
    run_until_done(0, n);
    tests_run++;
    if (n !== 5 || pass !== 1'b1) begin
      tests_failed++; $display("FAIL midread_rerun: got edges=%0d pass=%b expected 5 1", n, pass);
    end
  endtask

  task automatic test_random();
    int n, e, nacc, w0, w1;
    bit idm, tsm, to;
    logic [31:0] d0, d1, cap;
    for (int it = 0; it < 12; it++) begin
      w0 = $urandom_range(0, 6);
      w1 = $urandom_range(0, 6);
      d0 = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID;
      d1 = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_TS;
      config_slave(w0, w1, d0, d1, 1'b0);
      predict(w0, w1, d0, d1, e, idm, tsm, to, cap, nacc);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      run_until_done(1, n);
      tests_run++;
      if (n !== e || {id_mismatch, ts_mismatch, timeout} !== {idm, tsm, to} ||
          pass !== !(idm || tsm || to) || captured_ts !== cap || acc_q.size() != nacc ||
          proto_err != 0 || pass_glitch) begin
        tests_failed++;
        $display("FAIL random_%0d (w0=%0d w1=%0d): got edges=%0d id/ts/to=%b pass=%b cap=%h acc=%0d proto=%0d glitch=%0d expected edges=%0d id/ts/to=%b pass=%b cap=%h acc=%0d",
                 it, w0, w1, n, {id_mismatch, ts_mismatch, timeout}, pass, captured_ts,
                 acc_q.size(), proto_err, pass_glitch, e, {idm, tsm, to}, !(idm || tsm || to), cap, nacc);
      end
    end
  endtask

  initial begin
    config_slave(0, 0, EXP_ID, EXP_TS, 1'b0);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_ts_mismatch();
    test_timeout();
    test_start_ignored();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
